// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM pipeline stage: FSM states,
// load/store funct3 size codes and the write-back select value for loads.
package mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    localparam logic [2:0] LS_B    = 3'b000;
    localparam logic [2:0] LS_H    = 3'b001;
    localparam logic [2:0] LS_W    = 3'b010;
    localparam logic [2:0] LS_BU   = 3'b100;
    localparam logic [2:0] LS_HU   = 3'b101;

    localparam logic [2:0] WB_LOAD = 3'b001;

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/half lane of a data-memory word and
// sign- or zero-extends it according to the load funct3.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  strb,
    output logic [31:0] data
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte = rdata[7:0];
        case (addr_lo)
            2'd1:    lane_byte = rdata[15:8];
            2'd2:    lane_byte = rdata[23:16];
            2'd3:    lane_byte = rdata[31:24];
            default: lane_byte = rdata[7:0];
        endcase
        lane_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        data = rdata;
        case (strb)
            LS_B:    data = {{24{lane_byte[7]}}, lane_byte};
            LS_BU:   data = {24'h000000, lane_byte};
            LS_H:    data = {{16{lane_half[15]}}, lane_half};
            LS_HU:   data = {16'h0000, lane_half};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the RV32I pipeline: req/ack data-memory access, byte lanes, load extension, MEM/WB register.
// Optional MEM_TIMEOUT_EN: a WAIT lasting MAX_WAIT cycles without ack is abandoned and flagged in err_MEM.
module mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              regwrite_EX,
    input  logic              datawe_EX,
    input  logic [2:0]        wbsel_EX,
    input  logic [2:0]        strb_EX,
    input  logic [4:0]        rd_EX,
    input  logic [31:0]       aluout_EX,
    input  logic [31:0]       rdata2_EX,
    input  logic [31:0]       immext_EX,
    input  logic [31:0]       pcimmaui_EX,
    input  logic [31:0]       pcnext_EX,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_ack,
    output logic              stall_MEM,
    output logic              regwrite_MEM,
    output logic [2:0]        wbsel_MEM,
    output logic [4:0]        rd_MEM,
    output logic [31:0]       aluout_MEM,
    output logic [31:0]       rdata_MEM,
    output logic [31:0]       immext_MEM,
    output logic [31:0]       pcimmaui_MEM,
    output logic [31:0]       pcnext_MEM,
    output logic              err_MEM
);

    if (MAX_WAIT < 2) begin : g_max_wait_check
        $error("mem_stage: MAX_WAIT must be at least 2");
    end

    mem_state_t  state, state_next;
    logic        is_load, memop, misalign, access;
    logic        complete, timeout, err_now;
    logic [31:0] load_data;

    assign is_load  = (wbsel_EX == WB_LOAD);
    assign memop    = datawe_EX | is_load;
    assign misalign = (((strb_EX == LS_H) || (strb_EX == LS_HU)) && aluout_EX[0])
                    || ((strb_EX == LS_W) && (aluout_EX[1:0] != 2'b00));
    assign access   = memop & ~misalign;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
    logic [CNT_W-1:0] wait_count;

    assign timeout = (state == WAIT) && (wait_count == CNT_W'(MAX_WAIT));

    // Counts cycles spent in WAIT; preloaded to 1 so it equals the WAIT cycle index.
    always_ff @(posedge clk) begin
        if (rst)
            wait_count <= '0;
        else if (state == IDLE)
            wait_count <= CNT_W'(1);
        else
            wait_count <= wait_count + CNT_W'(1);
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Timeout wins over a coincident ack so dmem_req never depends on dmem_ack.
    always_comb begin
        state_next = state;
        dmem_req   = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                dmem_req = access;
                complete = access & dmem_ack;
                if (access && !dmem_ack)
                    state_next = WAIT;
            end
            WAIT: begin
                dmem_req = ~timeout;
                complete = timeout | dmem_ack;
                if (timeout || dmem_ack)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign stall_MEM = access & ~complete;
    assign dmem_we   = dmem_req & datawe_EX;
    assign dmem_addr = {aluout_EX[ADDR_W-1:2], 2'b00};

    always_comb begin
        dmem_be    = 4'b1111;
        dmem_wdata = rdata2_EX;
        case (strb_EX)
            LS_B, LS_BU: begin
                dmem_be    = 4'b0001 << aluout_EX[1:0];
                dmem_wdata = {4{rdata2_EX[7:0]}};
            end
            LS_H, LS_HU: begin
                dmem_be    = 4'b0011 << {aluout_EX[1], 1'b0};
                dmem_wdata = {2{rdata2_EX[15:0]}};
            end
            default: begin
                dmem_be    = 4'b1111;
                dmem_wdata = rdata2_EX;
            end
        endcase
        if (!access)
            dmem_be = 4'b0000;
    end

    load_align u_load_align (
        .rdata   (dmem_rdata),
        .addr_lo (aluout_EX[1:0]),
        .strb    (strb_EX),
        .data    (load_data)
    );

    assign err_now = (memop & misalign) | timeout;

    // A stalled cycle sends a bubble to WB; erroring instructions never write the register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            regwrite_MEM <= 1'b0;
            wbsel_MEM    <= '0;
            rd_MEM       <= '0;
            aluout_MEM   <= '0;
            rdata_MEM    <= '0;
            immext_MEM   <= '0;
            pcimmaui_MEM <= '0;
            pcnext_MEM   <= '0;
            err_MEM      <= 1'b0;
        end else if (stall_MEM) begin
            regwrite_MEM <= 1'b0;
            wbsel_MEM    <= '0;
            rd_MEM       <= '0;
            err_MEM      <= 1'b0;
        end else begin
            regwrite_MEM <= regwrite_EX & ~err_now;
            wbsel_MEM    <= wbsel_EX;
            rd_MEM       <= rd_EX;
            aluout_MEM   <= aluout_EX;
            rdata_MEM    <= (is_load && !err_now) ? load_data : 32'h0;
            immext_MEM   <= immext_EX;
            pcimmaui_MEM <= pcimmaui_EX;
            pcnext_MEM   <= pcnext_EX;
            err_MEM      <= err_now;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases from the test plan, then random
// loads/stores/ALU ops against a transaction-level model with a randomly delayed memory.
module tb_mem_stage;

    localparam int unsigned MAX_WAIT = 4;
    localparam int unsigned ADDR_W   = 32;
`ifdef MEM_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    typedef struct {
        int          kind;      // 0 = ALU op, 1 = load, 2 = store
        logic [2:0]  strb;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rword;
        logic [31:0] imm;
        logic [31:0] pcimm;
        logic [31:0] pcnext;
        logic [4:0]  rd;
        logic        regwrite;
        logic [2:0]  wbsel;
        int          delay;
    } txn_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              regwrite_EX, datawe_EX;
    logic [2:0]        wbsel_EX, strb_EX;
    logic [4:0]        rd_EX;
    logic [31:0]       aluout_EX, rdata2_EX, immext_EX, pcimmaui_EX, pcnext_EX;
    logic              dmem_req, dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_wdata;
    logic [3:0]        dmem_be;
    logic [31:0]       dmem_rdata;
    logic              dmem_ack;
    logic              stall_MEM;
    logic              regwrite_MEM;
    logic [2:0]        wbsel_MEM;
    logic [4:0]        rd_MEM;
    logic [31:0]       aluout_MEM, rdata_MEM, immext_MEM, pcimmaui_MEM, pcnext_MEM;
    logic              err_MEM;

    int errors = 0;
    int checks = 0;

    logic        exp_req, exp_we, exp_stall, exp_bubble;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr, exp_wdata;
    logic        exp_regwrite, exp_err;
    logic [2:0]  exp_wbsel;
    logic [4:0]  exp_rd;
    logic [31:0] exp_alu, exp_rdata, exp_imm, exp_pcimm, exp_pcnext;

    mem_stage #(.MAX_WAIT(MAX_WAIT), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .regwrite_EX  (regwrite_EX),
        .datawe_EX    (datawe_EX),
        .wbsel_EX     (wbsel_EX),
        .strb_EX      (strb_EX),
        .rd_EX        (rd_EX),
        .aluout_EX    (aluout_EX),
        .rdata2_EX    (rdata2_EX),
        .immext_EX    (immext_EX),
        .pcimmaui_EX  (pcimmaui_EX),
        .pcnext_EX    (pcnext_EX),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_be      (dmem_be),
        .dmem_rdata   (dmem_rdata),
        .dmem_ack     (dmem_ack),
        .stall_MEM    (stall_MEM),
        .regwrite_MEM (regwrite_MEM),
        .wbsel_MEM    (wbsel_MEM),
        .rd_MEM       (rd_MEM),
        .aluout_MEM   (aluout_MEM),
        .rdata_MEM    (rdata_MEM),
        .immext_MEM   (immext_MEM),
        .pcimmaui_MEM (pcimmaui_MEM),
        .pcnext_MEM   (pcnext_MEM),
        .err_MEM      (err_MEM)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic bit model_misalign(txn_t t);
        bit half_sz = (t.strb == 3'b001) || (t.strb == 3'b101);
        return (half_sz && (t.addr % 2 != 0)) || ((t.strb == 3'b010) && (t.addr % 4 != 0));
    endfunction

    function automatic bit model_access(txn_t t);
        return (t.kind != 0) && !model_misalign(t);
    endfunction

    function automatic logic [3:0] model_be(txn_t t);
        if (t.strb == 3'b000 || t.strb == 3'b100)
            return 4'(1 << (t.addr % 4));
        else if (t.strb == 3'b001 || t.strb == 3'b101)
            return ((t.addr % 4) >= 2) ? 4'd12 : 4'd3;
        else
            return 4'd15;
    endfunction

    function automatic logic [31:0] model_wdata(txn_t t);
        if (t.strb == 3'b000)
            return 32'(t.data[7:0]) * 32'h01010101;
        else if (t.strb == 3'b001)
            return 32'(t.data[15:0]) * 32'h00010001;
        else
            return t.data;
    endfunction

    function automatic logic [31:0] model_load(logic [31:0] word, logic [31:0] addr, logic [2:0] strb);
        logic [31:0] v;
        case (strb)
            3'b000, 3'b100: begin
                v = (word >> (8 * (addr % 4))) & 32'hFF;
                if (strb == 3'b000 && v >= 128) v = v - 32'd256;
            end
            3'b001, 3'b101: begin
                v = (word >> (16 * ((addr % 4) / 2))) & 32'hFFFF;
                if (strb == 3'b001 && v >= 32768) v = v - 32'd65536;
            end
            default: v = word;
        endcase
        return v;
    endfunction

    function automatic txn_t make_txn(int kind, logic [2:0] strb, logic [31:0] addr,
                                      logic [31:0] data, logic [31:0] rword, int delay);
        txn_t t;
        t.kind     = kind;
        t.strb     = strb;
        t.addr     = addr;
        t.data     = data;
        t.rword    = rword;
        t.delay    = delay;
        t.imm      = $urandom;
        t.pcimm    = $urandom;
        t.pcnext   = $urandom;
        t.rd       = 5'($urandom_range(1, 31));
        t.regwrite = (kind != 2);
        t.wbsel    = (kind == 1) ? 3'b001 : 3'b000;
        return t;
    endfunction

    function automatic txn_t random_txn();
        txn_t t;
        int   sel;
        int   dly;
        dly = $urandom_range(0, 4);
        t = make_txn($urandom_range(0, 2), 3'b000, $urandom, $urandom, $urandom, (dly == 4) ? 7 : dly);
        if (t.kind == 1) begin
            sel = $urandom_range(0, 4);
            t.strb = 3'((sel < 3) ? sel : sel + 1);
        end else if (t.kind == 2) begin
            t.strb = 3'($urandom_range(0, 2));
        end else begin
            t.strb     = 3'($urandom_range(0, 7));
            sel        = $urandom_range(0, 3);
            t.wbsel    = 3'((sel == 1) ? 4 : sel);
            t.regwrite = 1'($urandom_range(0, 1));
        end
        return t;
    endfunction

    task automatic applyStimulus(input txn_t t, input bit ack, input bit acc);
        regwrite_EX = t.regwrite;
        datawe_EX   = (t.kind == 2);
        wbsel_EX    = t.wbsel;
        strb_EX     = t.strb;
        rd_EX       = t.rd;
        aluout_EX   = t.addr;
        rdata2_EX   = t.data;
        immext_EX   = t.imm;
        pcimmaui_EX = t.pcimm;
        pcnext_EX   = t.pcnext;
        dmem_ack    = acc ? ack : 1'($urandom_range(0, 1));
        dmem_rdata  = dmem_ack ? t.rword : $urandom;
    endtask

    task automatic clear_inputs();
        regwrite_EX = 1'b0;
        datawe_EX   = 1'b0;
        wbsel_EX    = 3'b000;
        strb_EX     = 3'b000;
        rd_EX       = 5'd0;
        aluout_EX   = 32'h0;
        rdata2_EX   = 32'h0;
        immext_EX   = 32'h0;
        pcimmaui_EX = 32'h0;
        pcnext_EX   = 32'h0;
        dmem_ack    = 1'b0;
        dmem_rdata  = 32'h0;
    endtask

    task automatic checkOutput(input bit registered);
        if (!registered) begin
            check_val("dmem_req", 32'(dmem_req), 32'(exp_req));
            check_val("dmem_we", 32'(dmem_we), 32'(exp_we));
            check_val("stall_MEM", 32'(stall_MEM), 32'(exp_stall));
            check_val("dmem_be", 32'(dmem_be), 32'(exp_be));
            check_val("dmem_addr", 32'(dmem_addr), exp_addr);
            if (exp_we) check_val("dmem_wdata", dmem_wdata, exp_wdata);
        end else if (exp_bubble) begin
            check_val("bubble_regwrite", 32'(regwrite_MEM), 32'h0);
            check_val("bubble_wbsel", 32'(wbsel_MEM), 32'h0);
            check_val("bubble_err", 32'(err_MEM), 32'h0);
            check_val("bubble_rd", 32'(rd_MEM), 32'h0);
        end else begin
            check_val("regwrite_MEM", 32'(regwrite_MEM), 32'(exp_regwrite));
            check_val("wbsel_MEM", 32'(wbsel_MEM), 32'(exp_wbsel));
            check_val("rd_MEM", 32'(rd_MEM), 32'(exp_rd));
            check_val("err_MEM", 32'(err_MEM), 32'(exp_err));
            check_val("aluout_MEM", aluout_MEM, exp_alu);
            check_val("rdata_MEM", rdata_MEM, exp_rdata);
            check_val("immext_MEM", immext_MEM, exp_imm);
            check_val("pcimmaui_MEM", pcimmaui_MEM, exp_pcimm);
            check_val("pcnext_MEM", pcnext_MEM, exp_pcnext);
        end
    endtask

    // Holds one instruction in EX until the model says it leaves MEM; the memory acks after t.delay cycles.
    task automatic run_txn(input txn_t t, output int stall_cycles, output int req_cycles,
                           output logic [3:0] seen_be, output logic [31:0] seen_wdata);
        int waited;
        bit done, acc, tmo, ack_now, comp, err;
        waited = 0;
        done = 1'b0;
        stall_cycles = 0;
        req_cycles = 0;
        seen_be = 4'h0;
        seen_wdata = 32'h0;
        acc = model_access(t);
        while (!done) begin
            @(negedge clk);
            tmo     = TIMEOUT_EN && acc && (waited == int'(MAX_WAIT));
            ack_now = acc && !tmo && (waited == t.delay);
            comp    = ack_now || tmo;
            applyStimulus(t, ack_now, acc);
            exp_req      = acc && !tmo;
            exp_we       = exp_req && (t.kind == 2);
            exp_stall    = acc && !comp;
            exp_be       = acc ? model_be(t) : 4'h0;
            exp_addr     = t.addr & 32'hFFFF_FFFC;
            exp_wdata    = model_wdata(t);
            err          = ((t.kind != 0) && model_misalign(t)) || tmo;
            exp_bubble   = exp_stall;
            exp_regwrite = t.regwrite && !err;
            exp_wbsel    = t.wbsel;
            exp_rd       = t.rd;
            exp_err      = err;
            exp_alu      = t.addr;
            exp_rdata    = (t.kind == 1 && !err) ? model_load(t.rword, t.addr, t.strb) : 32'h0;
            exp_imm      = t.imm;
            exp_pcimm    = t.pcimm;
            exp_pcnext   = t.pcnext;
            #1;
            checkOutput(1'b0);
            if (dmem_req) begin
                req_cycles++;
                seen_be = dmem_be;
                seen_wdata = dmem_wdata;
            end
            if (stall_MEM) stall_cycles++;
            @(posedge clk);
            #1;
            checkOutput(1'b1);
            if (comp || !acc) done = 1'b1;
            else waited++;
        end
    endtask

    initial begin
        txn_t        t;
        int          sc, rc;
        logic [3:0]  be_seen;
        logic [31:0] wd_seen;

        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_req", 32'(dmem_req), 32'h0);
        check_val("reset_stall", 32'(stall_MEM), 32'h0);
        check_val("reset_regwrite", 32'(regwrite_MEM), 32'h0);
        check_val("reset_rdata", rdata_MEM, 32'h0);
        check_val("reset_err", 32'(err_MEM), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        check_val("pin_model_lb", model_load(32'h80112233, 32'h103, 3'b000), 32'hFFFFFF80);
        check_val("pin_model_lhu", model_load(32'h80112233, 32'h102, 3'b101), 32'h00008011);

        t = make_txn(1, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        run_txn(t, sc, rc, be_seen, wd_seen);
        check_val("lw_same_cycle_stalls", 32'(sc), 32'd0);
        check_val("lw_rdata", rdata_MEM, 32'hDEADBEEF);
        check_val("lw_regwrite", 32'(regwrite_MEM), 32'd1);

        t = make_txn(1, 3'b000, 32'h103, 32'h0, 32'h80112233, 3);
        run_txn(t, sc, rc, be_seen, wd_seen);
        check_val("lb_stall_cycles", 32'(sc), 32'd3);
        check_val("lb_rdata", rdata_MEM, 32'hFFFFFF80);

        t = make_txn(1, 3'b100, 32'h103, 32'h0, 32'h80112233, 1);
        run_txn(t, sc, rc, be_seen, wd_seen);
        check_val("lbu_rdata", rdata_MEM, 32'h00000080);

        t = make_txn(2, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 0);
        run_txn(t, sc, rc, be_seen, wd_seen);
        check_val("sh_be", 32'(be_seen), 32'h0000000C);
        check_val("sh_wdata", wd_seen, 32'hABCDABCD);
        check_val("sh_req_cycles", 32'(rc), 32'd1);

        t = make_txn(1, 3'b010, 32'h101, 32'h0, 32'h0, 0);
        run_txn(t, sc, rc, be_seen, wd_seen);
        check_val("misalign_req_cycles", 32'(rc), 32'd0);
        check_val("misalign_stalls", 32'(sc), 32'd0);
        check_val("misalign_err", 32'(err_MEM), 32'd1);
        check_val("misalign_regwrite", 32'(regwrite_MEM), 32'd0);

`ifdef MEM_TIMEOUT_EN
        t = make_txn(1, 3'b010, 32'h100, 32'h0, 32'h12345678, 7);
        run_txn(t, sc, rc, be_seen, wd_seen);
        check_val("timeout_req_cycles", 32'(rc), 32'd4);
        check_val("timeout_err", 32'(err_MEM), 32'd1);
        check_val("timeout_rdata", rdata_MEM, 32'h0);
`endif

        for (int i = 0; i < 300; i++) begin
            t = random_txn();
            run_txn(t, sc, rc, be_seen, wd_seen);
        end

        // Reset while an access is outstanding: the access is abandoned and the stage comes back idle.
        t = make_txn(1, 3'b010, 32'h300, 32'h0, 32'h55AA55AA, 7);
        @(negedge clk);
        applyStimulus(t, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;
        check_val("rst_wait_req", 32'(dmem_req), 32'h0);
        check_val("rst_wait_stall", 32'(stall_MEM), 32'h0);
        check_val("rst_wait_regwrite", 32'(regwrite_MEM), 32'h0);
        check_val("rst_wait_wbsel", 32'(wbsel_MEM), 32'h0);
        check_val("rst_wait_rd", 32'(rd_MEM), 32'h0);
        check_val("rst_wait_aluout", aluout_MEM, 32'h0);
        check_val("rst_wait_rdata", rdata_MEM, 32'h0);
        check_val("rst_wait_immext", immext_MEM, 32'h0);
        check_val("rst_wait_pcimmaui", pcimmaui_MEM, 32'h0);
        check_val("rst_wait_pcnext", pcnext_MEM, 32'h0);
        check_val("rst_wait_err", 32'(err_MEM), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("post_rst_req", 32'(dmem_req), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
